// File: rtl/sram_pkg.sv
// Shared constants, state encoding and level helper for the SRAM write path.
package sram_pkg;
    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;
    localparam int  ROWS = 4;
    localparam int  COLS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } wr_state_e;

    function automatic real lvl(input logic b);
        return b ? VDD : VSS;
    endfunction
endpackage

// File: rtl/sram_bl_driver.sv
// One column's bitline pair: converts an enable and a data bit into true/complement levels.
module sram_bl_driver (
    input  logic en,
    input  logic data,
    output real  bl,
    output real  blb
);
    import sram_pkg::*;

    assign bl  = lvl(en & data);
    assign blb = lvl(en & ~data);
endmodule

// File: rtl/sram_write_ctrl.sv
// Write sequencer: bitline setup, wordline pulse, hold, done. Optional read-back
// compare of the written row is enabled by defining SRAM_WR_VERIFY_EN.
module sram_write_ctrl #(
    parameter int ROWS      = sram_pkg::ROWS,
    parameter int COLS      = sram_pkg::COLS,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 3,
    parameter int HOLD_CYC  = 1,
    localparam int AW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
`ifdef SRAM_WR_VERIFY_EN
    input  real             bl_rd  [0:ROWS-1][0:COLS-1],
    input  real             blb_rd [0:ROWS-1][0:COLS-1],
    output logic            verify_err,
`endif
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [COLS-1:0] req_data,
    output logic            busy,
    output logic            done,
    output logic            addr_err,
    output real             row_wr [0:ROWS-1],
    output real             bl_wr  [0:0][0:COLS-1],
    output real             blb_wr [0:0][0:COLS-1]
);
    import sram_pkg::*;

    localparam int MAXC = (SETUP_CYC > PULSE_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    wr_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   addr_q;
    logic [COLS-1:0] data_q;
    logic [ROWS-1:0] row_q;
    logic            err_q;
    logic            bl_en_q;
    logic            req_ready_q;
    logic            busy_q;
    logic            done_q;
    logic            addr_err_q;
    logic            accept_s;
    logic            last_s;
    logic [ROWS-1:0] row_sel_s;

    assign accept_s = req_valid && req_ready_q;
    assign last_s   = (cnt_q == '0);

    // Wordline select for the latched address; an out-of-range address selects nothing.
    always_comb begin
        row_sel_s = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (!err_q && (addr_q == AW'(i))) begin
                row_sel_s[i] = 1'b1;
            end else begin
                row_sel_s[i] = 1'b0;
            end
        end
    end

`ifdef SRAM_WR_VERIFY_EN
    logic mismatch_s;
    logic verify_err_q;

    // Read-back compare against the latched word, thresholded at VTH.
    always_comb begin
        mismatch_s = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (!err_q && (((bl_rd[addr_q][c] >= VTH) != data_q[c]) ||
                           ((blb_rd[addr_q][c] >= VTH) == data_q[c]))) begin
                mismatch_s = 1'b1;
            end else begin
                mismatch_s = mismatch_s;
            end
        end
    end

    assign verify_err = verify_err_q;
`endif

    // Sequencer FSM; every output is registered on the transition into its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            row_q       <= '0;
            err_q       <= 1'b0;
            bl_en_q     <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_err_q  <= 1'b0;
`ifdef SRAM_WR_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
`ifdef SRAM_WR_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q     <= ST_SETUP;
                        cnt_q       <= CW'(SETUP_CYC - 1);
                        addr_q      <= req_addr;
                        data_q      <= req_data;
                        err_q       <= ({1'b0, req_addr} >= (AW+1)'(ROWS));
                        bl_en_q     <= 1'b1;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (last_s) begin
                        state_q <= ST_PULSE;
                        cnt_q   <= CW'(PULSE_CYC - 1);
                        row_q   <= row_sel_s;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_PULSE: begin
                    if (last_s) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= CW'(HOLD_CYC - 1);
                        row_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (last_s) begin
                        state_q    <= ST_DONE;
                        cnt_q      <= '0;
                        bl_en_q    <= 1'b0;
                        done_q     <= 1'b1;
                        addr_err_q <= err_q;
`ifdef SRAM_WR_VERIFY_EN
                        verify_err_q <= mismatch_s;
`endif
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    row_q       <= '0;
                    bl_en_q     <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign addr_err  = addr_err_q;

    // Wordline levels decoded straight from the one-hot row register.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_wr[r] = lvl(row_q[r]);
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        sram_bl_driver u_drv (
            .en   (bl_en_q),
            .data (data_q[c]),
            .bl   (bl_wr[0][c]),
            .blb  (blb_wr[0][c])
        );
    end
endmodule

// File: tb/tb_sram_write_ctrl.sv
// Bench for sram_write_ctrl: vector table, hand-written corner sequences and random traffic vs. a phase model.
`timescale 1ns/1ps
module tb_sram_write_ctrl;
    localparam int S   = 2;
    localparam int P   = 3;
    localparam int H   = 1;
    localparam int TOT = S + P + H + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, busy, done, addr_err;
    logic       req_ready3, busy3, done3, addr_err3;
    real        row_wr [0:3];
    real        bl_wr  [0:0][0:7];
    real        blb_wr [0:0][0:7];
    real        row_wr3 [0:2];
    real        bl_wr3  [0:0][0:7];
    real        blb_wr3 [0:0][0:7];

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction model: the active write is described only by its phase number since accept.
    bit         m_active = 1'b0;
    int         m_phase  = 0;
    logic [1:0] m_addr   = 2'd0;
    logic [7:0] m_data   = 8'h00;
    int         cyc      = 0;
    int         acc_cyc[$];
    logic [3:0] prev_rv  = 4'd0;
    logic [15:0] prev_bv = 16'd0;

`ifdef SRAM_WR_VERIFY_EN
    real  bl_rd  [0:3][0:7];
    real  blb_rd [0:3][0:7];
    real  bl_rd3  [0:2][0:7];
    real  blb_rd3 [0:2][0:7];
    logic verify_err, verify_err3;
    bit   force0 = 1'b0;

    // Ideal cell array: reads back what the bitlines drive; force0 pins column 0 low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                bl_rd[r][c]  = (force0 && c == 0) ? 0.0 : bl_wr[0][c];
                blb_rd[r][c] = blb_wr[0][c];
                if (r < 3) begin
                    bl_rd3[r][c]  = (force0 && c == 0) ? 0.0 : bl_wr3[0][c];
                    blb_rd3[r][c] = blb_wr3[0][c];
                end
            end
        end
    end
`endif

    sram_write_ctrl dut (
        .clk(clk), .rst(rst),
`ifdef SRAM_WR_VERIFY_EN
        .bl_rd(bl_rd), .blb_rd(blb_rd), .verify_err(verify_err),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .busy(busy), .done(done), .addr_err(addr_err),
        .row_wr(row_wr), .bl_wr(bl_wr), .blb_wr(blb_wr)
    );

    sram_write_ctrl #(.ROWS(3)) dut3 (
        .clk(clk), .rst(rst),
`ifdef SRAM_WR_VERIFY_EN
        .bl_rd(bl_rd3), .blb_rd(blb_rd3), .verify_err(verify_err3),
`endif
        .req_valid(req_valid), .req_ready(req_ready3), .req_addr(req_addr),
        .req_data(req_data), .busy(busy3), .done(done3), .addr_err(addr_err3),
        .row_wr(row_wr3), .bl_wr(bl_wr3), .blb_wr(blb_wr3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_r(input string name, input real got, input real exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %f expected %f", name, got, exp);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [3:0] rows_now();
        logic [3:0] v;
        for (int r = 0; r < 4; r++) v[r] = (row_wr[r] > 0.75);
        return v;
    endfunction

    function automatic logic [2:0] rows3_now();
        logic [2:0] v;
        for (int r = 0; r < 3; r++) v[r] = (row_wr3[r] > 0.75);
        return v;
    endfunction

    function automatic logic [15:0] bls_now();
        logic [15:0] v;
        for (int c = 0; c < 8; c++) begin
            v[c]     = (bl_wr[0][c] > 0.75);
            v[c + 8] = (blb_wr[0][c] > 0.75);
        end
        return v;
    endfunction

    task automatic check_outputs();
        bit pulse = m_active && (m_phase > S) && (m_phase <= S + P);
        bit drive = m_active && (m_phase <= S + P + H);
        bit dn    = m_active && (m_phase == TOT);
        logic [3:0]  rv = rows_now();
        logic [15:0] bv = bls_now();
        chk("req_ready", req_ready, !m_active);
        chk("busy", busy, m_active);
        chk("done", done, dn);
        chk("addr_err", addr_err, 1'b0);
        chk("req_ready3", req_ready3, !m_active);
        chk("busy3", busy3, m_active);
        chk("done3", done3, dn);
        chk("addr_err3", addr_err3, dn && (m_addr == 2'd3));
        for (int r = 0; r < 4; r++)
            chk_r($sformatf("row_wr[%0d]", r), row_wr[r], (pulse && m_addr == r) ? 1.5 : 0.0);
        for (int r = 0; r < 3; r++)
            chk_r($sformatf("row_wr3[%0d]", r), row_wr3[r], (pulse && m_addr == r) ? 1.5 : 0.0);
        for (int c = 0; c < 8; c++) begin
            chk_r($sformatf("bl_wr[%0d]", c), bl_wr[0][c], (drive && m_data[c]) ? 1.5 : 0.0);
            chk_r($sformatf("blb_wr[%0d]", c), blb_wr[0][c], (drive && !m_data[c]) ? 1.5 : 0.0);
            chk_r($sformatf("bl_wr3[%0d]", c), bl_wr3[0][c], (drive && m_data[c]) ? 1.5 : 0.0);
            chk_r($sformatf("blb_wr3[%0d]", c), blb_wr3[0][c], (drive && !m_data[c]) ? 1.5 : 0.0);
        end
        chk("row_onehot", ($countones(rv) <= 1), 1'b1);
        chk("no_overlap", !((rv != prev_rv) && (bv != prev_bv)), 1'b1);
`ifdef SRAM_WR_VERIFY_EN
        chk("verify_err", verify_err, dn && force0 && m_data[0]);
        chk("verify_err3", verify_err3, dn && force0 && m_data[0] && (m_addr != 2'd3));
`endif
        prev_rv = rv;
        prev_bv = bv;
    endtask

    task automatic tick();
        bit acc = req_valid && !m_active;
        @(posedge clk);
        cyc++;
        if (m_active) begin
            m_phase++;
            if (m_phase > TOT) m_active = 1'b0;
        end
        if (acc) begin
            m_active = 1'b1;
            m_phase  = 1;
            m_addr   = req_addr;
            m_data   = req_data;
            acc_cyc.push_back(cyc);
        end
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst req_ready", req_ready, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        for (int r = 0; r < 4; r++) chk_r($sformatf("rst row_wr[%0d]", r), row_wr[r], 0.0);
        for (int c = 0; c < 8; c++) begin
            chk_r($sformatf("rst bl_wr[%0d]", c), bl_wr[0][c], 0.0);
            chk_r($sformatf("rst blb_wr[%0d]", c), blb_wr[0][c], 0.0);
        end
        m_active = 1'b0;
        prev_rv  = 4'd0;
        prev_bv  = 16'd0;
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        logic [3:0] rows;
        logic       err3;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [7:0] pat;
        int n0, a1;
        vecs[0] = '{2'd0, 8'h00, 4'b0001, 1'b0};
        vecs[1] = '{2'd1, 8'hFF, 4'b0010, 1'b0};
        vecs[2] = '{2'd2, 8'h3C, 4'b0100, 1'b0};
        vecs[3] = '{2'd3, 8'h5A, 4'b1000, 1'b1};
        vecs[4] = '{2'd3, 8'h0F, 4'b1000, 1'b1};

        // Reset and idle.
        do_reset();
        tick();
        tick();

        // Single write addr 2, data A5 with explicit cycle expectations.
        pat       = 8'hA5;
        req_valid = 1'b1;
        req_addr  = 2'd2;
        req_data  = pat;
        for (int k = 1; k <= 8; k++) begin
            tick();
            req_valid = 1'b0;
            chk_r($sformatf("t2 row2 k%0d", k), row_wr[2], (k >= 3 && k <= 5) ? 1.5 : 0.0);
            chk($sformatf("t2 done k%0d", k), done, (k == 7));
            if (k == 1)
                for (int c = 0; c < 8; c++)
                    chk_r($sformatf("t2 bl[%0d]", c), bl_wr[0][c], pat[c] ? 1.5 : 0.0);
        end

        // Vector table.
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = vecs[i].addr;
            req_data  = vecs[i].data;
            for (int k = 1; k <= TOT + 1; k++) begin
                tick();
                req_valid = 1'b0;
                if (k == 1) chk_i($sformatf("v%0d bl", i), int'(bls_now()), int'({~vecs[i].data, vecs[i].data}));
                if (k == S + 1) begin
                    chk_i($sformatf("v%0d rows", i), int'(rows_now()), int'(vecs[i].rows));
                    chk_i($sformatf("v%0d rows3", i), int'(rows3_now()), int'(vecs[i].rows[2:0]));
                end
                if (k == TOT) begin
                    chk($sformatf("v%0d done3", i), done3, 1'b1);
                    chk($sformatf("v%0d addr_err3", i), addr_err3, vecs[i].err3);
                end
            end
        end

        // Back-to-back with req_valid held high.
        req_valid = 1'b1;
        req_addr  = 2'd0;
        req_data  = 8'hC3;
        n0 = acc_cyc.size();
        for (int i = 0; i < 20 && acc_cyc.size() == n0; i++) tick();
        chk("b2b first accept", (acc_cyc.size() > n0), 1'b1);
        a1       = acc_cyc[$];
        req_addr = 2'd1;
        req_data = 8'h3C;
        n0 = acc_cyc.size();
        for (int i = 0; i < 20 && acc_cyc.size() == n0; i++) tick();
        chk("b2b second accept", (acc_cyc.size() > n0), 1'b1);
        chk_i("b2b spacing", acc_cyc[$] - a1, TOT + 1);
        req_valid = 1'b0;
        for (int i = 0; i < TOT + 1; i++) tick();

        // Reset in the middle of the wordline pulse.
        req_valid = 1'b1;
        req_addr  = 2'd1;
        req_data  = 8'h96;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk_r("mid pulse row1", row_wr[1], 1.5);
        do_reset();
        for (int i = 0; i < 10; i++) tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
`ifdef SRAM_WR_VERIFY_EN
            if (!m_active) force0 = ($urandom_range(0, 1) == 1);
`endif
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = 2'($urandom_range(0, 3));
            req_data  = 8'($urandom);
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < TOT + 2; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
